// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit (producer side of the if_id -> id path)
//
// Holds the PC, issues pipelined word fetches over a req/gnt/rvalid handshake,
// buffers returned words in a 2-entry FIFO and presents them downstream with
// valid/hold flow control. A redirect (jump) flushes the FIFO and discards
// every response still in flight for the old stream.
//
// Optional feature macro: IFU_BYPASS_EN
//   defined   : a response arriving while the FIFO is empty (and nothing is
//               being dropped) is shown on inst_o in the same cycle.
//   undefined : every response passes through the FIFO (grant N -> valid N+2).
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   jump_en_i, jump_addr_i         redirect request and target (bits [1:0] ignored)
//   hold_i                         downstream stall
//   imem_req_o, imem_addr_o        fetch request and word-aligned address (= pc)
//   imem_gnt_i                     request accepted (req & gnt)
//   imem_rvalid_i, imem_rdata_i    in-order response
//   inst_o, instaddr_o             instruction and its address to if_id
//   inst_valid_o                   inst_o / instaddr_o valid
// ----------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] instaddr_o,
  output logic        inst_valid_o
);

  // Program counter
  logic [31:0]      pc_q, pc_d;
  // In-flight address queue: its occupancy is exactly outst_q
  logic [1:0][31:0] aq_addr_q, aq_addr_d;
  logic             aq_rd_q, aq_rd_d;
  logic             aq_wr_q, aq_wr_d;
  logic [1:0]       outst_q, outst_d;
  // Number of in-flight responses that belong to a redirected-away stream
  logic [1:0]       drop_cnt_q, drop_cnt_d;
  // Output FIFO
  logic [1:0][31:0] fifo_addr_q, fifo_addr_d;
  logic [1:0][31:0] fifo_data_q, fifo_data_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;

  logic        credit_s;
  logic        req_s;
  logic        gnt_fire_s;
  logic        drop_resp_s;
  logic        keep_resp_s;
  logic        fifo_valid_s;
  logic        bypass_s;
  logic        push_s;
  logic        pop_s;
  logic [31:0] aq_head_s;

  // Handshake qualifiers and flow-control decisions for the current cycle.
  always_comb begin
    // Credit counts both in-flight words and buffered words, so the FIFO
    // can always absorb every response that is still on its way.
    credit_s     = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < 3'd2;
    req_s        = rstn & ~jump_en_i & credit_s;
    gnt_fire_s   = req_s & imem_gnt_i;
    drop_resp_s  = imem_rvalid_i & (drop_cnt_q != 2'd0);
    // A response landing in a jump cycle belongs to the old stream.
    keep_resp_s  = imem_rvalid_i & (drop_cnt_q == 2'd0) & ~jump_en_i;
    fifo_valid_s = (fifo_cnt_q != 2'd0);
    aq_head_s    = aq_addr_q[aq_rd_q];
`ifdef IFU_BYPASS_EN
    bypass_s     = keep_resp_s & ~fifo_valid_s;
`else
    bypass_s     = 1'b0;
`endif
    pop_s        = fifo_valid_s & ~hold_i & ~jump_en_i;
    // A bypassed word consumed this cycle never enters the FIFO.
    push_s       = keep_resp_s & ~(bypass_s & ~hold_i);
  end

  // Fetch-side and downstream outputs.
  always_comb begin
    imem_req_o  = req_s;
    imem_addr_o = pc_q;
    if (fifo_valid_s) begin
      inst_o       = fifo_data_q[fifo_rd_q];
      instaddr_o   = fifo_addr_q[fifo_rd_q];
      inst_valid_o = 1'b1;
    end else if (bypass_s) begin
      inst_o       = imem_rdata_i;
      instaddr_o   = aq_head_s;
      inst_valid_o = 1'b1;
    end else begin
      inst_o       = NOP_INST;
      instaddr_o   = 32'h0000_0000;
      inst_valid_o = 1'b0;
    end
  end

  // Next-state for PC, in-flight tracking and the drop counter.
  always_comb begin
    if (jump_en_i) begin
      pc_d = jump_addr_i & 32'hFFFF_FFFC;
    end else if (gnt_fire_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    aq_addr_d = aq_addr_q;
    if (gnt_fire_s) begin
      aq_addr_d[aq_wr_q] = pc_q;
      aq_wr_d            = ~aq_wr_q;
    end else begin
      aq_wr_d            = aq_wr_q;
    end
    // Every response, kept or dropped, retires the oldest in-flight address.
    aq_rd_d = aq_rd_q ^ imem_rvalid_i;
    outst_d = outst_q + {1'b0, gnt_fire_s} - {1'b0, imem_rvalid_i};

    // On a jump every response still pending after this cycle is stale.
    if (jump_en_i) begin
      drop_cnt_d = outst_q - {1'b0, imem_rvalid_i};
    end else if (drop_resp_s) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Next-state for the output FIFO (flushed on jump).
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (jump_en_i) begin
      fifo_rd_d  = 1'b0;
      fifo_wr_d  = 1'b0;
      fifo_cnt_d = 2'd0;
    end else begin
      if (push_s) begin
        fifo_addr_d[fifo_wr_q] = aq_head_s;
        fifo_data_d[fifo_wr_q] = imem_rdata_i;
        fifo_wr_d              = ~fifo_wr_q;
      end else begin
        fifo_wr_d              = fifo_wr_q;
      end
      fifo_rd_d  = fifo_rd_q ^ pop_s;
      fifo_cnt_d = fifo_cnt_q + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q        <= RESET_PC;
      aq_addr_q   <= '0;
      aq_rd_q     <= 1'b0;
      aq_wr_q     <= 1'b0;
      outst_q     <= 2'd0;
      drop_cnt_q  <= 2'd0;
      fifo_addr_q <= '0;
      fifo_data_q <= '0;
      fifo_rd_q   <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      pc_q        <= pc_d;
      aq_addr_q   <= aq_addr_d;
      aq_rd_q     <= aq_rd_d;
      aq_wr_q     <= aq_wr_d;
      outst_q     <= outst_d;
      drop_cnt_q  <= drop_cnt_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_ifu_fetch -- self-checking bench for ifu_fetch.
// A reset/idle vector table, then scripted and random traffic against a
// scoreboard: granted addresses queue as in-flight, kept responses queue as
// expected outputs, and each consumed output is popped and compared.
// A second instance with RESET_PC = FFFF_FFF8 checks PC wrap from reset.
// ----------------------------------------------------------------------------
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFU_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [31:0] addr;
    bit          drop;
  } fl_t;

  typedef struct {
    bit          rstn;
    bit          jump;
    logic [31:0] jaddr;
    bit          hold;
    bit          gnt;
    bit          exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn, jump_en, hold, gnt, rvalid;
  logic [31:0] jump_addr, rdata;
  logic        req, valid;
  logic [31:0] addr, inst, instaddr;
  logic        req_hi, rvalid_hi, valid_hi;
  logic [31:0] addr_hi, rdata_hi, inst_hi, instaddr_hi;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          first_grant = -1;
  int          first_valid = -1;
  fl_t         mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  bit          obs_valid, obs_req;
  logic [31:0] obs_addr;
  int          hi_n = 0;
  logic [31:0] hi_seen [3];
  logic [31:0] hi_exp [3];
  vec_t        vt [7];

  always #5 clk = ~clk;

  ifu_fetch u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .hold_i       (hold),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_gnt_i   (gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .inst_o       (inst),
    .instaddr_o   (instaddr),
    .inst_valid_o (valid)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk          (clk),
    .rstn         (rstn),
    .jump_en_i    (1'b0),
    .jump_addr_i  (32'h0000_0000),
    .hold_i       (1'b0),
    .imem_req_o   (req_hi),
    .imem_addr_o  (addr_hi),
    .imem_gnt_i   (1'b1),
    .imem_rvalid_i(rvalid_hi),
    .imem_rdata_i (rdata_hi),
    .inst_o       (inst_hi),
    .instaddr_o   (instaddr_hi),
    .inst_valid_o (valid_hi)
  );

  // One-cycle memory for the high-reset instance (always grants).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_hi <= 1'b0;
      rdata_hi  <= 32'h0;
    end else begin
      rvalid_hi <= req_hi;
      rdata_hi  <= addr_hi;
    end
  end

  // Record the first three delivered addresses of the high-reset instance.
  always_ff @(negedge clk) begin
    if (valid_hi && hi_n < 3) begin
      hi_seen[hi_n] <= instaddr_hi;
      hi_n          <= hi_n + 1;
    end
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus plus scoreboard update.
  task automatic step(input bit j, input logic [31:0] ja, input bit h, input bit g, input bit rv_en);
    bit  exp_req, exp_valid, byp;
    fl_t f;
    @(negedge clk);
    cyc++;
    jump_en   = j;
    jump_addr = ja;
    hold      = h;
    gnt       = g;
    rvalid    = rv_en && (mem_q.size() != 0);
    rdata     = rvalid ? data_of(mem_q[0].addr) : $urandom;
    exp_req   = !j && ((mem_q.size() + exp_q.size()) < 2);
    #1;
    obs_valid = valid;
    obs_addr  = instaddr;
    obs_req   = req;
    if (valid && first_valid < 0) first_valid = cyc;
    check("imem_req", req, exp_req);
    check("imem_addr", addr, m_pc);
    if (j) foreach (mem_q[i]) mem_q[i].drop = 1'b1;
    exp_valid = (exp_q.size() != 0);
    byp       = 1'b0;
`ifdef IFU_BYPASS_EN
    if (!exp_valid && rvalid && !j && !mem_q[0].drop) begin
      f = mem_q.pop_front();
      exp_q.push_back(f.addr);
      exp_valid = 1'b1;
      byp       = 1'b1;
    end
`endif
    check("inst_valid", valid, exp_valid);
    if (exp_valid) begin
      check("instaddr", instaddr, exp_q[0]);
      check("inst", inst, data_of(exp_q[0]));
      if (!h && !j) void'(exp_q.pop_front());
    end else begin
      check("inst_nop", inst, NOP);
      check("instaddr_zero", instaddr, 32'h0);
    end
    if (rvalid && !byp) begin
      f = mem_q.pop_front();
      if (!f.drop) exp_q.push_back(f.addr);
    end
    if (j) begin
      exp_q.delete();
      m_pc = ja & 32'hFFFF_FFFC;
    end else if (exp_req && g) begin
      mem_q.push_back(fl_t'{addr: m_pc, drop: 1'b0});
      if (first_grant < 0) first_grant = cyc;
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Stream until the DUT shows a valid output, then compare its address.
  task automatic wait_valid(input string nm, input logic [31:0] exp);
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      if (obs_valid) begin
        check(nm, obs_addr, exp);
        found = 1'b1;
      end
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no valid output within 20 cycles, expected %h", nm, exp);
    end
  endtask

  task automatic stream(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rstn = 1'b0; jump_en = 1'b0; jump_addr = 32'h0; hold = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    //            rstn  jump  jaddr          hold  gnt   exp_req exp_addr
    vt[0] = vec_t'{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vt[1] = vec_t'{1'b0, 1'b1, 32'h0000_0044, 1'b1, 1'b1, 1'b0, 32'h0000_0000};
    vt[2] = vec_t'{1'b1, 1'b1, 32'h0000_0047, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vt[3] = vec_t'{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0044};
    vt[4] = vec_t'{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0044};
    vt[5] = vec_t'{1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0044};
    vt[6] = vec_t'{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000};
    hi_exp[0] = 32'hFFFF_FFF8;
    hi_exp[1] = 32'hFFFF_FFFC;
    hi_exp[2] = 32'h0000_0000;

    foreach (vt[i]) begin
      @(negedge clk);
      rstn = vt[i].rstn; jump_en = vt[i].jump; jump_addr = vt[i].jaddr;
      hold = vt[i].hold; gnt = vt[i].gnt; rvalid = 1'b0;
      #1;
      check("tbl_req", req, vt[i].exp_req);
      check("tbl_addr", addr, vt[i].exp_addr);
      check("tbl_valid", valid, 1'b0);
      check("tbl_inst", inst, NOP);
      check("tbl_instaddr", instaddr, 32'h0);
    end
    m_pc = 32'h0;

    // Streaming from reset and first-instruction latency
    stream(12);
    check("first_latency", first_valid - first_grant, LAT);

    // Downstream hold mid-stream
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check("hold_req_low", obs_req, 1'b0);
    stream(8);

    // Two requests outstanding, then redirect to an unaligned target
    drain();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0103, 1'b0, 1'b1, 1'b0);
    check("jump_req_low", obs_req, 1'b0);
    wait_valid("jump_target", 32'h0000_0100);
    stream(4);

    // Jump together with a returning response while an instruction is held
    drain();
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("valid_after_jump", obs_valid, 1'b0);
    wait_valid("jump_hold_target", 32'h0000_0200);
    stream(4);

    // Back-to-back jumps
    stream(3);
    step(1'b1, 32'h0000_0300, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0400, 1'b0, 1'b1, 1'b1);
    wait_valid("b2b_target", 32'h0000_0400);

    // PC wrap on the main instance
    step(1'b1, 32'hFFFF_FFF5, 1'b0, 1'b1, 1'b1);
    wait_valid("wrap_first", 32'hFFFF_FFF4);
    stream(8);

    // Random traffic: gaps in grant and response, holds and jumps
    for (int k = 0; k < 200; k++)
      step(($urandom % 12) == 0, $urandom, ($urandom % 4) == 0,
           ($urandom % 3) != 0, ($urandom % 4) != 0);

    // Asynchronous reset pulse between clock edges
    stream(6);
    @(negedge clk);
    jump_en = 1'b0; gnt = 1'b0; rvalid = 1'b0; hold = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("arst_req", req, 1'b0);
    check("arst_addr", addr, 32'h0);
    check("arst_valid", valid, 1'b0);
    check("arst_inst", inst, NOP);
    check("arst_instaddr", instaddr, 32'h0);
    #1 rstn = 1'b1;
    mem_q.delete();
    exp_q.delete();
    m_pc = 32'h0;
    wait_valid("restart_addr", 32'h0000_0000);
    stream(6);

    // High reset-PC instance: wrap through zero
    check("hi_count", hi_n, 3);
    for (int k = 0; k < 3; k++) check("hi_instaddr", hi_seen[k], hi_exp[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
